wave_rom_scheduler: RTL and testbench
=====================================

Name: wave_rom_scheduler

Overview:
- Time-multiplexes one synchronous waveform ROM among VOICES voices. The ROM has a 1-cycle read latency.
- Each cycle it issues at most one ROM read, visiting enabled voices round-robin in ascending index order. Each returned sample lands in that voice's holding register.
- Sits between the per-voice wave counters (source of note addresses and enables) and the waveform combiner (consumer of samples).
- Replaces the free-running mod-3 select counters. Disabled voices are skipped, so enabled voices are refreshed faster.

Parameters:
VOICES, 3, number of voices sharing the ROM (1..8)
ADDR_W, 12, ROM address width
DATA_W, 8, ROM data / sample width

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
enables  input  VOICES  per-voice enable; bit v high = voice v sounding
note_addrs  input  VOICES*ADDR_W  packed ROM addresses; voice v at [v*ADDR_W +: ADDR_W]
rom_en  output  1  ROM read strobe (registered)
rom_addr  output  ADDR_W  ROM read address (registered)
rom_data  input  DATA_W  ROM read data, valid the cycle after rom_en
samples  output  VOICES*DATA_W  packed per-voice sample registers, same packing as note_addrs
sample_valid  output  VOICES  1-cycle pulse, bit v high in the cycle samples slice v first shows a new value
frame_done  output  1  1-cycle pulse marking completion of a round

Behaviour:
- Reset values (asynchronous):
  - State IDLE; rom_en=0; rom_addr=0.
  - samples all 0; sample_valid=0; frame_done=0.
  - Pipeline valid bits cleared; round_mask=0.
  - A rom_data return for a read issued before reset is ignored.
- States:
  - IDLE: no read issued.
  - SCAN: one read per cycle.
- Round start:
  - In IDLE, or in SCAN after the last issue of a round, the block latches round_mask <= enables.
  - If that mask is 0, it goes to or stays in IDLE.
  - Otherwise it goes to SCAN with ptr set to the lowest set bit.
- Issue (SCAN):
  - On each edge: rom_en <= 1; rom_addr <= note_addrs slice ptr; issue_voice <= ptr.
  - ptr advances to the next higher set bit of round_mask. Cleared bits cost zero cycles.
  - When no higher bit remains, that issue is the round's last; it is tagged last and a new round starts on the following edge with no bubble.
  - Back-to-back rounds give a continuous rom_en=1.
- When not issuing, rom_en <= 0 and rom_addr holds its last value.
- Return pipeline:
  - The edge after an issue registers rom_data into samples slice issue_voice and pulses sample_valid[issue_voice].
  - Latency is 2 cycles from rom_en high to the sample being visible.
- frame_done pulses in the same cycle as sample_valid for the read tagged last.
- Enable dropped mid-round:
  - The voice stays in round_mask, so the ROM is still read.
  - Any voice whose live enables bit is 0 has its sample slice forced to 0 every edge, and its write and sample_valid are suppressed.
  - frame_done still pulses for a suppressed last read.
- Enable raised mid-round: the voice takes effect at the next round start.
- Simultaneity: at most one sample_valid bit is high per cycle. A forced zero and an idle voice have no conflict.
- Single enabled voice: that voice is read every cycle, and frame_done pulses every cycle after the 2-cycle fill.
- note_addrs is sampled only at issue; later changes do not affect in-flight reads.
- Reset asserted mid-SCAN: everything returns to reset values immediately. The first issue after release occurs on the second edge after deassert: one edge latches the round, the next issues.

Test Plan:
- Reset, then enables=3'b111, note_addrs={12'h300,12'h200,12'h100}, ROM model data=addr[7:0] -> rom_addr sequence 100,200,300,100…; rom_en continuous; samples={00,00,00} updated with voice0=00 first; sample_valid cycles 001,010,100; frame_done with each 100.
- enables=3'b101 -> rom_addr alternates 100/300; voice1 sample stays 0; frame_done every 2nd cycle.
- enables=3'b000 after running -> IDLE, rom_en=0 within 2 cycles, all samples 0, no frame_done.
- Drop enables[1] while voice1's read is in flight -> no sample_valid[1], samples slice1=0, frame_done timing unchanged; voice1 absent from next round.
- Assert rst for 1 cycle mid-round with a read outstanding -> all outputs 0 asynchronously, stale rom_data not captured, first post-reset rom_en on 2nd edge after deassert.
- VOICES=4, enables=4'b1000 -> rom_addr=voice3 address every cycle, frame_done every cycle after 2-cycle fill.

Source files
------------

// File: rtl/wave_rom_scheduler_if.sv
// Voice-side and ROM-side signals of the shared waveform ROM scheduler.
// The master drives enables, addresses and ROM data; the slave is the scheduler.
interface wave_rom_scheduler_if #(
  parameter int VOICES = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
);
  logic [VOICES-1:0]        enables;
  logic [VOICES*ADDR_W-1:0] note_addrs;
  logic                     rom_en;
  logic [ADDR_W-1:0]        rom_addr;
  logic [DATA_W-1:0]        rom_data;
  logic [VOICES*DATA_W-1:0] samples;
  logic [VOICES-1:0]        sample_valid;
  logic                     frame_done;

  modport master (
    output enables, note_addrs, rom_data,
    input  rom_en, rom_addr, samples, sample_valid, frame_done
  );

  modport slave (
    input  enables, note_addrs, rom_data,
    output rom_en, rom_addr, samples, sample_valid, frame_done
  );
endinterface

// File: rtl/wave_rom_scheduler.sv
// Round-robin sharing of one 1-cycle-latency waveform ROM among enabled voices.
// Sample visible 2 cycles after rom_en; no backpressure, one read per cycle while scanning.
module wave_rom_scheduler #(
  parameter int VOICES = 3,
  parameter int ADDR_W = 12,
  parameter int DATA_W = 8
) (
  input logic                clk,
  input logic                rst,
  wave_rom_scheduler_if.slave bus
);
  localparam int PTR_W = (VOICES > 1) ? $clog2(VOICES) : 1;

  typedef enum logic {IDLE, SCAN} state_t;

  state_t                   r_state, w_state_nxt;
  logic [VOICES-1:0]        r_round_mask, w_round_mask_nxt;
  logic [PTR_W-1:0]         r_ptr, w_ptr_nxt;
  logic                     w_issue, w_last, w_has_hi;
  logic [PTR_W-1:0]         w_next_hi, w_lowest_en;
  logic [ADDR_W-1:0]        w_sel_addr;

  logic                     r_rom_en;
  logic [ADDR_W-1:0]        r_rom_addr;
  logic [PTR_W-1:0]         r_iss_voice, r_ret_voice;
  logic                     r_iss_last, r_ret_vld, r_ret_last;
  logic [VOICES*DATA_W-1:0] r_samples;
  logic [VOICES-1:0]        r_sample_valid;
  logic                     r_frame_done;

  // Descending scans so the lowest qualifying index wins.
  always_comb begin
    w_has_hi    = 1'b0;
    w_next_hi   = '0;
    w_lowest_en = '0;
    w_sel_addr  = '0;
    for (int v = VOICES - 1; v >= 0; v--) begin
      if (r_round_mask[v] && (PTR_W'(v) > r_ptr)) begin
        w_has_hi  = 1'b1;
        w_next_hi = PTR_W'(v);
      end
      if (bus.enables[v]) begin
        w_lowest_en = PTR_W'(v);
      end
    end
    for (int v = 0; v < VOICES; v++) begin
      if (PTR_W'(v) == r_ptr) begin
        w_sel_addr = bus.note_addrs[v*ADDR_W +: ADDR_W];
      end
    end
  end

  always_comb begin
    w_state_nxt      = r_state;
    w_round_mask_nxt = r_round_mask;
    w_ptr_nxt        = r_ptr;
    w_issue          = (r_state == SCAN);
    w_last           = w_issue && !w_has_hi;
    if (!w_issue || w_last) begin
      // Round boundary: the next round's mask is latched on the last issue edge, so no bubble.
      w_round_mask_nxt = bus.enables;
      if (bus.enables == '0) begin
        w_state_nxt = IDLE;
      end else begin
        w_state_nxt = SCAN;
        w_ptr_nxt   = w_lowest_en;
      end
    end else begin
      w_ptr_nxt = w_next_hi;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_round_mask <= '0;
      r_ptr        <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_round_mask <= w_round_mask_nxt;
      r_ptr        <= w_ptr_nxt;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rom_en    <= 1'b0;
      r_rom_addr  <= '0;
      r_iss_voice <= '0;
      r_iss_last  <= 1'b0;
      r_ret_vld   <= 1'b0;
      r_ret_voice <= '0;
      r_ret_last  <= 1'b0;
    end else begin
      r_rom_en <= w_issue;
      if (w_issue) begin
        r_rom_addr  <= w_sel_addr;
        r_iss_voice <= r_ptr;
        r_iss_last  <= w_last;
      end
      // Second stage lines up with rom_data arriving from the ROM.
      r_ret_vld   <= r_rom_en;
      r_ret_voice <= r_iss_voice;
      r_ret_last  <= r_rom_en && r_iss_last;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_samples      <= '0;
      r_sample_valid <= '0;
      r_frame_done   <= 1'b0;
    end else begin
      r_sample_valid <= '0;
      r_frame_done   <= r_ret_vld && r_ret_last;
      for (int v = 0; v < VOICES; v++) begin
        if (!bus.enables[v]) begin
          r_samples[v*DATA_W +: DATA_W] <= '0;
        end else if (r_ret_vld && (r_ret_voice == PTR_W'(v))) begin
          r_samples[v*DATA_W +: DATA_W] <= bus.rom_data;
          r_sample_valid[v]             <= 1'b1;
        end
      end
    end
  end

  assign bus.rom_en       = r_rom_en;
  assign bus.rom_addr     = r_rom_addr;
  assign bus.samples      = r_samples;
  assign bus.sample_valid = r_sample_valid;
  assign bus.frame_done   = r_frame_done;
endmodule

// File: tb/tb_wave_rom_scheduler.sv
// Bench for wave_rom_scheduler: a queue-based round model checks a 3-voice instance cycle by cycle;
// a 4-voice instance covers the single-voice case with directed expectations.
module tb_wave_rom_scheduler;
  logic clk;
  logic rst;
  int   n_cmp;
  int   n_err;

  wave_rom_scheduler_if #(.VOICES(3), .ADDR_W(12), .DATA_W(8)) bus ();
  wave_rom_scheduler_if #(.VOICES(4), .ADDR_W(12), .DATA_W(8)) bus4 ();

  wave_rom_scheduler #(.VOICES(3), .ADDR_W(12), .DATA_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));
  wave_rom_scheduler #(.VOICES(4), .ADDR_W(12), .DATA_W(8)) dut4 (.clk(clk), .rst(rst), .bus(bus4));

  always #5 clk = ~clk;

  function automatic logic [7:0] romf(input logic [11:0] a);
    return a[7:0] ^ {a[11:8], a[11:8]};
  endfunction

  // Synchronous ROMs, deliberately not reset so stale returns exist across a reset.
  always @(posedge clk) if (bus.rom_en) bus.rom_data <= romf(bus.rom_addr);
  always @(posedge clk) if (bus4.rom_en) bus4.rom_data <= romf(bus4.rom_addr);

  // Reference model: a round is the ascending list of enabled voices taken at round start.
  logic        m_en, m_fd;
  logic [11:0] m_addr;
  logic [23:0] m_samp;
  logic [2:0]  m_valid;
  int          q[$];
  logic        p1_vld, p1_last, p2_vld, p2_last;
  int          p1_v, p2_v;
  logic [11:0] p1_addr, p2_addr;

  initial begin
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        m_en = 0; m_fd = 0; m_addr = 0; m_samp = 0; m_valid = 0;
        p1_vld = 0; p2_vld = 0; p1_last = 0; p2_last = 0;
        q.delete();
      end else begin
        m_fd = 0;
        m_valid = 0;
        if (p2_vld) begin
          if (bus.enables[p2_v]) begin
            m_samp[p2_v*8 +: 8] = romf(p2_addr);
            m_valid[p2_v] = 1;
          end
          m_fd = p2_last;
        end
        for (int v = 0; v < 3; v++) if (!bus.enables[v]) m_samp[v*8 +: 8] = 0;
        p2_vld = p1_vld; p2_v = p1_v; p2_addr = p1_addr; p2_last = p1_last;
        if (q.size() > 0) begin
          p1_v    = q.pop_front();
          p1_vld  = 1;
          p1_addr = bus.note_addrs[p1_v*12 +: 12];
          p1_last = (q.size() == 0);
          m_en    = 1;
          m_addr  = p1_addr;
        end else begin
          p1_vld = 0;
          p1_last = 0;
          m_en = 0;
        end
        if (q.size() == 0 && (p1_last || !p1_vld))
          for (int v = 0; v < 3; v++) if (bus.enables[v]) q.push_back(v);
      end
    end
  end

  wire [40:0] dut_vec = {bus.rom_en, bus.rom_addr, bus.samples, bus.sample_valid, bus.frame_done};
  wire [40:0] exp_vec = {m_en, m_addr, m_samp, m_valid, m_fd};

  task automatic test_reset();
    @(negedge clk);
    n_cmp++;
    if (dut_vec !== 41'h0) begin
      n_err++; $display("FAIL reset_state: got %h want %h", dut_vec, 41'h0);
    end
    n_cmp++;
    if ({bus4.rom_en, bus4.frame_done, bus4.sample_valid, bus4.samples} !== 38'h0) begin
      n_err++; $display("FAIL reset_state4: got %h want 0", {bus4.rom_en, bus4.frame_done, bus4.sample_valid, bus4.samples});
    end
    rst = 0;
  endtask

  task automatic test_all_voices();
    bus.note_addrs = {12'h3a7, 12'h25c, 12'h1e1};
    bus.enables = 3'b111;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL all_voices cyc %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if (i >= 2) begin
        n_cmp++;
        if (bus.rom_en !== 1'b1) begin
          n_err++; $display("FAIL continuous_rom_en cyc %0d: got %b want 1", i, bus.rom_en);
        end
      end
    end
  endtask

  task automatic test_partial();
    bus.enables = 3'b101;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL partial cyc %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      n_cmp++;
      if (bus.samples[15:8] !== 8'h0) begin
        n_err++; $display("FAIL partial_voice1_zero cyc %0d: got %h want 00", i, bus.samples[15:8]);
      end
    end
  endtask

  task automatic test_drop_midround();
    bit found = 0;
    bus.enables = 3'b111;
    for (int i = 0; i < 12 && !found; i++) begin
      @(negedge clk);
      if (bus.rom_en === 1'b1 && bus.rom_addr === bus.note_addrs[23:12]) found = 1;
    end
    n_cmp++;
    if (!found) begin
      n_err++; $display("FAIL drop_wait: got timeout want voice1 issue");
    end
    bus.enables = 3'b101;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL drop cyc %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      n_cmp++;
      if (bus.sample_valid[1] !== 1'b0 || bus.samples[15:8] !== 8'h0) begin
        n_err++; $display("FAIL drop_voice1 cyc %0d: got v=%b s=%h want v=0 s=00", i, bus.sample_valid[1], bus.samples[15:8]);
      end
    end
  endtask

  task automatic test_idle();
    bus.enables = 3'b000;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL idle cyc %0d: got %h want %h", i, dut_vec, exp_vec);
      end
    end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.rom_en, bus.frame_done, bus.samples} !== 26'h0) begin
        n_err++; $display("FAIL idle_quiet cyc %0d: got %h want 0", i, {bus.rom_en, bus.frame_done, bus.samples});
      end
    end
  endtask

  task automatic test_reset_midround();
    bus.enables = 3'b111;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL pre_rst cyc %0d: got %h want %h", i, dut_vec, exp_vec);
      end
    end
    rst = 1;
    #1;
    n_cmp++;
    if (dut_vec !== 41'h0) begin
      n_err++; $display("FAIL async_reset: got %h want %h", dut_vec, 41'h0);
    end
    @(negedge clk);
    rst = 0;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (k <= 2) begin
        n_cmp++;
        if (bus.rom_en !== (k == 2)) begin
          n_err++; $display("FAIL post_rst_issue edge %0d: got %b want %b", k, bus.rom_en, k == 2);
        end
      end
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL post_rst cyc %0d: got %h want %h", k, dut_vec, exp_vec);
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n_cmp++;
      if (dut_vec !== exp_vec) begin
        n_err++; $display("FAIL random cyc %0d: got %h want %h", i, dut_vec, exp_vec);
      end
      if ($urandom_range(5) == 0) bus.enables = 3'($urandom);
      if ($urandom_range(9) == 0) bus.note_addrs = 36'({$urandom, $urandom});
    end
  endtask

  task automatic test_single_voice();
    logic [11:0] a3;
    logic [31:0] exp_s;
    bus4.note_addrs = 48'({$urandom, $urandom});
    a3 = bus4.note_addrs[47:36];
    bus4.enables = 4'b1000;
    for (int k = 1; k <= 10; k++) begin
      @(negedge clk);
      exp_s = (k >= 4) ? {romf(a3), 24'h0} : 32'h0;
      n_cmp++;
      if (bus4.rom_en !== (k >= 2)) begin
        n_err++; $display("FAIL single_rom_en edge %0d: got %b want %b", k, bus4.rom_en, k >= 2);
      end
      if (k >= 2) begin
        n_cmp++;
        if (bus4.rom_addr !== a3) begin
          n_err++; $display("FAIL single_rom_addr edge %0d: got %h want %h", k, bus4.rom_addr, a3);
        end
      end
      n_cmp++;
      if (bus4.frame_done !== (k >= 4) || bus4.sample_valid !== ((k >= 4) ? 4'b1000 : 4'b0000)) begin
        n_err++; $display("FAIL single_pulses edge %0d: got fd=%b sv=%b want fd=%b", k, bus4.frame_done, bus4.sample_valid, k >= 4);
      end
      n_cmp++;
      if (bus4.samples !== exp_s) begin
        n_err++; $display("FAIL single_samples edge %0d: got %h want %h", k, bus4.samples, exp_s);
      end
    end
  endtask

  initial begin
    clk = 0;
    rst = 0;
    n_cmp = 0;
    n_err = 0;
    bus.enables = 0;
    bus.note_addrs = 0;
    bus4.enables = 0;
    bus4.note_addrs = 0;
    #3 rst = 1;
    test_reset();
    test_all_voices();
    test_partial();
    test_drop_midround();
    test_idle();
    test_reset_midround();
    test_random();
    test_single_voice();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
